// File: rtl/cnter_pkg.sv
// Shared constants for the counter bank.
// Mode encodings and per-channel reset defaults.
package cnter_pkg;

  localparam logic SAT_WRAP = 1'b0;
  localparam logic SAT_SAT  = 1'b1;

  // Truncated to WIDTH where used.
  localparam logic [31:0] LIMIT_RST = '1;
  localparam int          STEP_RST  = 1;

endpackage

// File: rtl/cnter_ch.sv
// One counter channel: count, limit, step and mode registers.
// Ports: cfg_*, wrt/din load, ev count event -> data, wrap_now, at_limit.
module cnter_ch
  import cnter_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_wr,
  input  logic [WIDTH-1:0] cfg_limit,
  input  logic [WIDTH-1:0] cfg_step,
  input  logic             cfg_sat,
  input  logic             wrt,
  input  logic [WIDTH-1:0] din,
  input  logic             ev,
  output logic [WIDTH-1:0] data,
  output logic             wrap_now,
  output logic             at_limit
);

  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] step;
  logic             sat;
  logic [WIDTH:0]   sum;
  logic             over;
  logic [WIDTH-1:0] nxt;

  always_comb begin
    sum      = {1'b0, data} + {1'b0, step};
    over     = sum > {1'b0, limit};
    nxt      = data;
    wrap_now = 1'b0;
    if (ev) begin
      if (!over) begin
        nxt = sum[WIDTH-1:0];
      end else if (sat == SAT_SAT) begin
        // Pulse only on reaching saturation, not while held there.
        nxt      = limit;
        wrap_now = (data != limit);
      end else begin
        nxt      = '0;
        wrap_now = 1'b1;
      end
    end
    // A load wins over the event, so nothing ripples downstream.
    if (wrt) wrap_now = 1'b0;
  end

  assign at_limit = (data == limit);

  always_ff @(posedge clk) begin
    if (reset)    data <= '0;
    else if (wrt) data <= din;
    else          data <= nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      limit <= LIMIT_RST[WIDTH-1:0];
      step  <= WIDTH'(STEP_RST);
      sat   <= SAT_WRAP;
    end else if (cfg_wr) begin
      limit <= cfg_limit;
      step  <= cfg_step;
      sat   <= cfg_sat;
    end
  end

endmodule

// File: rtl/cnter_bank.sv
// Bank of NUM_CH chainable loadable counters.
// Ports: cfg_* config write, chain_en, wrt/dataIn load, cnt -> dataOut, at_limit, wrap.
module cnter_bank
  import cnter_pkg::*;
#(
  parameter int WIDTH  = 5,
  parameter int NUM_CH = 4,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cfg_wrt,
  input  logic [CH_W-1:0]         cfg_ch,
  input  logic [WIDTH-1:0]        cfg_limit,
  input  logic [WIDTH-1:0]        cfg_step,
  input  logic                    cfg_sat,
  input  logic [NUM_CH-1:0]       chain_en,
  input  logic [NUM_CH-1:0]       wrt,
  input  logic [NUM_CH*WIDTH-1:0] dataIn,
  input  logic [NUM_CH-1:0]       cnt,
  output logic [NUM_CH*WIDTH-1:0] dataOut,
  output logic [NUM_CH-1:0]       at_limit,
  output logic [NUM_CH-1:0]       wrap
);

  logic [NUM_CH-1:0] wrap_now;
  logic              unused_chain0;

  // Channel 0 has no predecessor to chain from.
  assign unused_chain0 = chain_en[0];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic ev;
    logic wn;
    logic cfg_hit;

    if (i == 0) begin : g_head
      assign ev = cnt[0];
    end else begin : g_link
      // Ripples through every channel within one cycle.
      assign ev = chain_en[i] ? g_ch[i-1].wn : cnt[i];
    end

    assign cfg_hit = cfg_wrt &&
                     ({1'b0, cfg_ch} == (CH_W+1)'(i));

    cnter_ch #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .cfg_wr   (cfg_hit),
      .cfg_limit(cfg_limit),
      .cfg_step (cfg_step),
      .cfg_sat  (cfg_sat),
      .wrt      (wrt[i]),
      .din      (dataIn[i*WIDTH +: WIDTH]),
      .ev       (ev),
      .data     (dataOut[i*WIDTH +: WIDTH]),
      .wrap_now (wn),
      .at_limit (at_limit[i])
    );

    assign wrap_now[i] = wn;
  end

  always_ff @(posedge clk) begin
    if (reset) wrap <= '0;
    else       wrap <= wrap_now;
  end

endmodule
